// File: rtl/sdft_pkg.sv
// rtl/sdft_pkg.sv - shared FSM state type and width helpers for the sdft readout path
package sdft_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_CORE = 3'd1,
      ST_ADDR      = 3'd2,
      ST_CAPTURE   = 3'd3,
      ST_EMIT      = 3'd4
   } reader_state_e;

   // One extra bit keeps abs(-2^(w-1)) and the |re|+|im| sum exact.
   localparam int MAG_EXTRA_BITS = 1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int mag_width(input int bw);
      return bw + MAG_EXTRA_BITS;
   endfunction

endpackage

// File: rtl/sdft_l1_mag.sv
// rtl/sdft_l1_mag.sv - registered L1 magnitude |re|+|im| of one complex bin, one-cycle latency
module sdft_l1_mag
   import sdft_pkg::*;
#(
   parameter  int bin_width = 16,
   localparam int mag_w     = mag_width(bin_width)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic signed [bin_width-1:0] re,
   input  logic signed [bin_width-1:0] im,
   output logic [mag_w-1:0]            mag
);

   logic signed [mag_w-1:0] re_x, im_x;
   logic [mag_w-1:0]        re_abs, im_abs;
   logic [mag_w-1:0]        mag_q, mag_d;

   always_comb begin
      re_x   = mag_w'(re);
      im_x   = mag_w'(im);
      re_abs = re_x[mag_w-1] ? $unsigned(-re_x) : $unsigned(re_x);
      im_abs = im_x[mag_w-1] ? $unsigned(-im_x) : $unsigned(im_x);
      mag_d  = en ? (re_abs + im_abs) : mag_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mag_q <= '0;
      end else begin
         mag_q <= mag_d;
      end
   end

   assign mag = mag_q;

endmodule

// File: rtl/sdft_bin_reader.sv
// rtl/sdft_bin_reader.sv - frame readout of sdft bins as an L1-magnitude stream
// Optional peak tracker built when SDFT_READER_PEAK_EN is defined.
module sdft_bin_reader
   import sdft_pkg::*;
#(
   parameter  int freq_bins = 128,
   parameter  int bin_width = 16,
   parameter  int out_bins  = freq_bins / 2,
   localparam int idx_w     = idx_width(freq_bins),
   localparam int mag_w     = mag_width(bin_width)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_start,
   input  logic                        sdft_ready,
   output logic                        busy,
   output logic [idx_w-1:0]            bin_addr,
   input  logic signed [bin_width-1:0] bin_real,
   input  logic signed [bin_width-1:0] bin_imag,
   output logic [mag_w-1:0]            mag,
   output logic [idx_w-1:0]            mag_index,
   output logic                        mag_last,
   output logic                        mag_valid,
`ifdef SDFT_READER_PEAK_EN
   output logic [idx_w-1:0]            peak_index,
   output logic [mag_w-1:0]            peak_mag,
`endif
   input  logic                        mag_ready
);

   reader_state_e    state_q, state_d;
   logic [idx_w-1:0] index_q, index_d;
   logic [idx_w-1:0] mag_index_q, mag_index_d;
   logic             mag_last_q, mag_last_d;
   logic             capture, handshake;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (frame_start) state_d = ST_WAIT_CORE;
         ST_WAIT_CORE: if (sdft_ready)  state_d = ST_ADDR;
         ST_ADDR:      state_d = ST_CAPTURE;
         ST_CAPTURE:   state_d = ST_EMIT;
         ST_EMIT:      if (mag_ready)   state_d = mag_last_q ? ST_IDLE : ST_ADDR;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      mag_valid = (state_q == ST_EMIT);
      capture   = (state_q == ST_CAPTURE);
      handshake = (state_q == ST_EMIT) && mag_ready;
   end

   // Output fields load only in CAPTURE, so they stay frozen under back-pressure.
   always_comb begin
      index_d     = index_q;
      mag_index_d = mag_index_q;
      mag_last_d  = mag_last_q;
      if ((state_q == ST_IDLE) && frame_start) begin
         index_d = '0;
      end
      if (capture) begin
         mag_index_d = index_q;
         mag_last_d  = (index_q == idx_w'(out_bins - 1));
      end
      if (handshake && !mag_last_q) begin
         index_d = index_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index_q     <= '0;
         mag_index_q <= '0;
         mag_last_q  <= 1'b0;
      end else begin
         index_q     <= index_d;
         mag_index_q <= mag_index_d;
         mag_last_q  <= mag_last_d;
      end
   end

   assign bin_addr  = index_q;
   assign mag_index = mag_index_q;
   assign mag_last  = mag_last_q;

   sdft_l1_mag #(
      .bin_width (bin_width)
   ) u_l1_mag (
      .clk   (clk),
      .reset (reset),
      .en    (capture),
      .re    (bin_real),
      .im    (bin_imag),
      .mag   (mag)
   );

`ifdef SDFT_READER_PEAK_EN
   logic [mag_w-1:0] run_mag_q, run_mag_d, peak_mag_q, peak_mag_d, cand_mag;
   logic [idx_w-1:0] run_idx_q, run_idx_d, peak_idx_q, peak_idx_d, cand_idx;
   logic             take_new;

   // Strict greater-than keeps the lower index on ties; bin 0 seeds the running max.
   always_comb begin
      take_new   = (mag_index_q == '0) || (mag > run_mag_q);
      cand_mag   = take_new ? mag : run_mag_q;
      cand_idx   = take_new ? mag_index_q : run_idx_q;
      run_mag_d  = run_mag_q;
      run_idx_d  = run_idx_q;
      peak_mag_d = peak_mag_q;
      peak_idx_d = peak_idx_q;
      if (handshake) begin
         run_mag_d = cand_mag;
         run_idx_d = cand_idx;
         if (mag_last_q) begin
            peak_mag_d = cand_mag;
            peak_idx_d = cand_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_mag_q  <= '0;
         run_idx_q  <= '0;
         peak_mag_q <= '0;
         peak_idx_q <= '0;
      end else begin
         run_mag_q  <= run_mag_d;
         run_idx_q  <= run_idx_d;
         peak_mag_q <= peak_mag_d;
         peak_idx_q <= peak_idx_d;
      end
   end

   assign peak_index = peak_idx_q;
   assign peak_mag   = peak_mag_q;
`else
`endif

endmodule
